code_word_arbiter: RTL and testbench



---
 rtl/vend_pkg.sv | 23 ++
 rtl/rr_pick.sv | 35 +++
 rtl/code_word_arbiter.sv | 110 +++++++++++
 tb/tb_code_word_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: FSM states, prefix byte, the code transform.
package vend_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned GID_W  = 2;
    localparam int unsigned GAP_W  = 4;

    localparam logic [CODE_W-1:0] PREFIX = 8'h88;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // The existing 8-to-16 code transform: prefix byte above the raw code.
    function automatic logic [WORD_W-1:0] code_xform(input logic [CODE_W-1:0] prefix,
                                                     input logic [CODE_W-1:0] code);
        return {prefix, code};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req_valid  : per-requester request vector
//   last_grant : index granted most recently; search starts just above it
//   winner     : first valid index from last_grant+1 upward, modulo N_REQ
//   any_valid  : at least one request present
module rr_pick
    import vend_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GID_W-1:0] last_grant,
    output logic [GID_W-1:0] winner,
    output logic             any_valid
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    int idx;

    // Rotating priority search; the first hit after last_grant wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = (int'(last_grant) + k) % int'(N_REQ);
            if (!any_valid && req_valid[IW'(idx)]) begin
                any_valid = 1'b1;
                winner    = GID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/code_word_arbiter.sv
// Round-robin arbiter sharing the 8-to-16 code transform between requesters.
//   clk, reset : clock and synchronous active-high reset
//   req_valid  : per-requester code available
//   req_code   : packed codes, requester i at [8*i+7:8*i]
//   req_ready  : one-hot accept strobe (combinational, IDLE only)
//   out_word   : {PREFIX, captured code}, valid while out_valid
//   out_valid  : out_word presented to the sink
//   out_ready  : sink accepts out_word
//   grant_id   : requester whose word is in flight
//   busy       : high whenever not IDLE
module code_word_arbiter
    import vend_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter logic [7:0]  PREFIX     = vend_pkg::PREFIX,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [CODE_W*N_REQ-1:0] req_code,
    output logic [N_REQ-1:0]        req_ready,
    output logic [WORD_W-1:0]       out_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy
);

    state_t            state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GID_W-1:0]  last_grant;
    logic [GID_W-1:0]  winner;
    logic              any_valid;
    logic              accept;
    logic [CODE_W-1:0] sel_code;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    // Code of the current winner.
    always_comb begin
        sel_code = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner == GID_W'(i)) begin
                sel_code = req_code[CODE_W*i +: CODE_W];
            end
        end
    end

    // Accept strobe is masked during reset so no requester sees a phantom accept.
    assign accept    = !reset && (state == S_IDLE) && any_valid;
    assign req_ready = accept ? (N_REQ'(1) << winner) : '0;

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            out_word   <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            gap_cnt    <= '0;
            last_grant <= GID_W'(N_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        out_word   <= code_xform(PREFIX, sel_code);
                        grant_id   <= winner;
                        last_grant <= winner;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_word_arbiter.sv
// Bench for code_word_arbiter: instance 0 uses GAP_CYCLES=2, instance 1 GAP_CYCLES=0.
module tb_code_word_arbiter;

    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_code;
    logic        out_ready;

    logic [2:0]  rdy [2];
    logic [15:0] ow  [2];
    logic        ov  [2];
    logic [1:0]  gid [2];
    logic        bsy [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    code_word_arbiter #(.N_REQ(3), .PREFIX(8'h88), .GAP_CYCLES(2)) dut_gap2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code),
        .req_ready(rdy[0]), .out_word(ow[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .grant_id(gid[0]), .busy(bsy[0])
    );

    code_word_arbiter #(.N_REQ(3), .PREFIX(8'h88), .GAP_CYCLES(0)) dut_gap0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code),
        .req_ready(rdy[1]), .out_word(ow[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .grant_id(gid[1]), .busy(bsy[1])
    );

    // Behavioural model: a word is either in flight or not; after a handshake the
    // next accept may happen no earlier than handshake cycle + 1 + gap.
    int          cyc = 0;
    bit          armed = 1'b0;
    bit          m_infl [2];
    logic [15:0] m_word [2];
    int          m_gid  [2];
    int          m_last [2];
    int          m_earl [2];
    int          e_win;
    logic [2:0]  e_rdy;

    // Hand-written expectations for instance 0, pinned by the directed tests.
    bit          lit_chk = 1'b0;
    bit          lit_cw;
    logic        lit_v;
    logic [15:0] lit_w;
    logic [1:0]  lit_g;
    logic [2:0]  lit_r;

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int rr_win(input int last, input logic [2:0] v);
        for (int s = 1; s <= NR; s++) begin
            if (v[(last + s) % NR]) return (last + s) % NR;
        end
        return -1;
    endfunction

    task automatic check(input int k, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_win = rr_win(m_last[k], req_valid);
            e_rdy = (!reset && !m_infl[k] && cyc >= m_earl[k] && e_win >= 0)
                    ? (3'(1) << e_win) : 3'b000;
            if (armed) begin
                check(k, "out_valid", 32'(ov[k]),  32'(m_infl[k]));
                check(k, "busy",      32'(bsy[k]), 32'(m_infl[k] || cyc < m_earl[k]));
                check(k, "grant_id",  32'(gid[k]), 32'(m_gid[k]));
                check(k, "req_ready", 32'(rdy[k]), 32'(e_rdy));
                if (m_infl[k]) check(k, "out_word", 32'(ow[k]), 32'(m_word[k]));
            end
            if (reset) begin
                m_infl[k] = 1'b0;
                m_gid[k]  = 0;
                m_last[k] = NR - 1;
                m_earl[k] = cyc + 1;
            end else if (m_infl[k]) begin
                if (out_ready) begin
                    m_infl[k] = 1'b0;
                    m_earl[k] = cyc + 1 + gap_of(k);
                end
            end else if (e_rdy != 3'b000) begin
                m_infl[k] = 1'b1;
                m_word[k] = {8'h88, 8'(req_code >> (8 * e_win))};
                m_gid[k]  = e_win;
                m_last[k] = e_win;
            end
        end
        if (armed && lit_chk) begin
            check(0, "lit_out_valid", 32'(ov[0]),  32'(lit_v));
            check(0, "lit_grant_id",  32'(gid[0]), 32'(lit_g));
            check(0, "lit_req_ready", 32'(rdy[0]), 32'(lit_r));
            if (lit_cw) check(0, "lit_out_word", 32'(ow[0]), 32'(lit_w));
        end
        if (reset) armed = 1'b1;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input logic v, input logic [15:0] w, input logic [1:0] g,
                              input logic [2:0] r, input bit cw);
        lit_v = v; lit_w = w; lit_g = g; lit_r = r; lit_cw = cw;
        lit_chk = 1'b1;
        @(negedge clk);
        #1;
        lit_chk = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 3'b000; req_code = '0; out_ready = 1'b1;
        step(); step();

        // Single request, then a second one held through the gap.
        reset = 1'b0; req_valid = 3'b001; req_code[7:0] = 8'h35;
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b001, 1'b1);
        step(); req_valid = 3'b000;
        expect_lit(1'b1, 16'h8835, 2'd0, 3'b000, 1'b1);
        step(); req_valid = 3'b001; req_code[7:0] = 8'h36;
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b000, 1'b0);
        step();
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b000, 1'b0);
        step();
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b001, 1'b0);
        step(); req_valid = 3'b000;
        expect_lit(1'b1, 16'h8836, 2'd0, 3'b000, 1'b1);
        step(); step(); step();

        // Round-robin with all three requesters held high.
        reset = 1'b1; step();
        reset = 1'b0; req_valid = 3'b111; req_code = {8'h03, 8'h02, 8'h01}; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_lit(i % 4 == 1, {8'h88, 8'((i / 4) % 3 + 1)},
                       (i == 0) ? 2'd0 : 2'(((i - 1) / 4) % 3),
                       (i % 4 == 0) ? (3'(1) << ((i / 4) % 3)) : 3'b000, i % 4 == 1);
            step();
        end

        // Backpressure, then a wrap from last grant 2 to requester 1.
        req_valid = 3'b000; reset = 1'b1; step();
        reset = 1'b0; out_ready = 1'b0; req_valid = 3'b111; req_code = {8'h03, 8'h02, 8'hA7};
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b001, 1'b0);
        step();
        for (int j = 1; j <= 5; j++) begin
            if (j == 5) begin
                out_ready = 1'b1; req_valid = 3'b100; req_code[23:16] = 8'h55;
            end
            expect_lit(1'b1, 16'h88A7, 2'd0, 3'b000, 1'b1);
            step();
        end
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b000, 1'b0); step();
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b000, 1'b0); step();
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b100, 1'b0); step();
        req_valid = 3'b010; req_code[15:8] = 8'h44;
        expect_lit(1'b1, 16'h8855, 2'd2, 3'b000, 1'b1); step();
        expect_lit(1'b0, 16'h0000, 2'd2, 3'b000, 1'b0); step();
        expect_lit(1'b0, 16'h0000, 2'd2, 3'b000, 1'b0); step();
        expect_lit(1'b0, 16'h0000, 2'd2, 3'b010, 1'b0); step();
        req_valid = 3'b000;
        expect_lit(1'b1, 16'h8844, 2'd1, 3'b000, 1'b1); step();

        // Reset while a word is in flight.
        reset = 1'b1; step();
        reset = 1'b0; req_valid = 3'b001; req_code[7:0] = 8'h12; out_ready = 1'b0;
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b001, 1'b0); step();
        reset = 1'b1; req_valid = 3'b111;
        expect_lit(1'b1, 16'h8812, 2'd0, 3'b000, 1'b1); step();
        reset = 1'b0; req_code = {8'h03, 8'h02, 8'h01}; out_ready = 1'b1;
        expect_lit(1'b0, 16'h0000, 2'd0, 3'b001, 1'b0); step();
        expect_lit(1'b1, 16'h8801, 2'd0, 3'b000, 1'b1); step();

        // Random traffic against the model for both gap settings.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req_valid = 3'($urandom_range(0, 7));
            req_code  = 24'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; req_valid = 3'b000;
        step(); step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
